// File: rtl/led_breath_monitor.sv
// Receive-side monitor for a breathing-LED PWM stream: measures lit cycles per window,
// decodes the active LED, tracks breath phase and flags multi-hot vectors.
// Optional LED_MON_STATS_EN adds a 16-bit breath_cnt output counting completed breaths.
module led_breath_monitor #(
  parameter int WINDOW = 6,
  parameter int DUTY_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        led_in,
  input  logic              sync_clr,
  output logic [DUTY_W-1:0] duty_out,
  output logic              meas_valid,
  output logic [2:0]        led_idx,
  output logic              led_change,
  output logic [1:0]        phase,
  output logic              breath_done,
  output logic              onehot_err
`ifdef LED_MON_STATS_EN
  ,
  output logic [15:0]       breath_cnt
`endif
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  localparam logic [1:0] PH_IDLE    = 2'b00;
  localparam logic [1:0] PH_RISING  = 2'b01;
  localparam logic [1:0] PH_FALLING = 2'b10;

  logic [CNT_W-1:0]  win_cnt;
  logic [DUTY_W-1:0] acc;
  logic [DUTY_W-1:0] prev_duty;
  logic              seen;

  logic              lit;
  logic              multi;
  logic              onehot;
  logic [2:0]        idx_enc;
  logic              win_close;
  logic [DUTY_W-1:0] duty_next;
  logic [1:0]        phase_next;
  logic              done_next;

  // x & (x-1) clears the lowest set bit; anything left means more than one LED lit.
  always_comb begin
    lit    = (led_in != 8'h00);
    multi  = ((led_in & (led_in - 8'h01)) != 8'h00);
    onehot = lit && !multi;
  end

  always_comb begin
    idx_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (led_in[i]) idx_enc = 3'(i);
    end
  end

  always_comb begin
    win_close = (win_cnt == LAST_CNT);
    duty_next = acc + DUTY_W'(lit);
  end

  // Phase decisions use the count of the window closing this cycle against the previous one.
  always_comb begin
    phase_next = phase;
    done_next  = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (duty_next != '0) phase_next = PH_RISING;
      end
      PH_RISING: begin
        if (duty_next < prev_duty)      phase_next = PH_FALLING;
        else if (duty_next == '0)       phase_next = PH_IDLE;
      end
      PH_FALLING: begin
        if (duty_next == '0) begin
          phase_next = PH_IDLE;
          done_next  = 1'b1;
        end else if (duty_next > prev_duty) begin
          phase_next = PH_RISING;
        end
      end
      default: phase_next = PH_IDLE;
    endcase
  end

  // Window, duty and phase tracking; sync_clr overrides a coincident window close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      acc         <= '0;
      prev_duty   <= '0;
      duty_out    <= '0;
      meas_valid  <= 1'b0;
      phase       <= PH_IDLE;
      breath_done <= 1'b0;
    end else if (sync_clr) begin
      win_cnt     <= '0;
      acc         <= '0;
      prev_duty   <= '0;
      meas_valid  <= 1'b0;
      phase       <= PH_IDLE;
      breath_done <= 1'b0;
    end else if (win_close) begin
      win_cnt     <= '0;
      acc         <= '0;
      prev_duty   <= duty_next;
      duty_out    <= duty_next;
      meas_valid  <= 1'b1;
      phase       <= phase_next;
      breath_done <= done_next;
    end else begin
      win_cnt     <= win_cnt + CNT_W'(1);
      acc         <= duty_next;
      meas_valid  <= 1'b0;
      breath_done <= 1'b0;
    end
  end

  // LED index decoding; the seen flag keeps the first one-hot sample from reporting a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_idx    <= 3'd0;
      led_change <= 1'b0;
      seen       <= 1'b0;
    end else if (sync_clr) begin
      led_change <= 1'b0;
      seen       <= 1'b0;
    end else if (onehot) begin
      led_idx    <= idx_enc;
      led_change <= seen && (idx_enc != led_idx);
      seen       <= 1'b1;
    end else begin
      led_change <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     onehot_err <= 1'b0;
    else if (multi) onehot_err <= 1'b1;
  end

`ifdef LED_MON_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              breath_cnt <= 16'd0;
    else if (!sync_clr && win_close && done_next) breath_cnt <= breath_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_led_breath_monitor.sv
// Directed bench for led_breath_monitor: a window-level vector table plus hand sequences
// for LED change, multi-hot, sync_clr collisions and mid-window reset.
module tb_led_breath_monitor;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RISE = 2'b01;
  localparam logic [1:0] FALL = 2'b10;

  logic       clk;
  logic       rst_n;
  logic [7:0] led_in;
  logic       sync_clr;
  logic [3:0] duty_out;
  logic       meas_valid;
  logic [2:0] led_idx;
  logic       led_change;
  logic [1:0] phase;
  logic       breath_done;
  logic       onehot_err;
`ifdef LED_MON_STATS_EN
  logic [15:0] breath_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  led_breath_monitor #(.WINDOW(6), .DUTY_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .sync_clr(sync_clr),
    .duty_out(duty_out), .meas_valid(meas_valid), .led_idx(led_idx),
    .led_change(led_change), .phase(phase), .breath_done(breath_done),
    .onehot_err(onehot_err)
`ifdef LED_MON_STATS_EN
    , .breath_cnt(breath_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr_before;
    logic [7:0] led;
    int         lit;
    logic [3:0] exp_duty;
    logic [1:0] exp_phase;
    logic       exp_done;
    logic [2:0] exp_idx;
  } win_vec_t;

  win_vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [7:0] led, input logic clr);
    led_in   = led;
    sync_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input win_vec_t v);
    if (v.clr_before) tick(8'h00, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick((c < v.lit) ? v.led : 8'h00, 1'b0);
      check("win_meas_valid", meas_valid, (c == 5) ? 1 : 0);
      check("win_breath_done", breath_done, (c == 5) ? int'(v.exp_done) : 0);
      check("win_led_change", led_change, 0);
    end
    check("win_duty", duty_out, v.exp_duty);
    check("win_phase", phase, v.exp_phase);
    check("win_idx", led_idx, v.exp_idx);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h04, 3, 4'd3, RISE, 1'b0, 3'd2};
    vecs[1] = '{1'b0, 8'h04, 3, 4'd3, RISE, 1'b0, 3'd2};
    vecs[2] = '{1'b1, 8'h01, 1, 4'd1, RISE, 1'b0, 3'd0};
    vecs[3] = '{1'b0, 8'h01, 2, 4'd2, RISE, 1'b0, 3'd0};
    vecs[4] = '{1'b0, 8'h01, 3, 4'd3, RISE, 1'b0, 3'd0};
    vecs[5] = '{1'b0, 8'h01, 3, 4'd3, RISE, 1'b0, 3'd0};
    vecs[6] = '{1'b0, 8'h01, 2, 4'd2, FALL, 1'b0, 3'd0};
    vecs[7] = '{1'b0, 8'h01, 1, 4'd1, FALL, 1'b0, 3'd0};
    vecs[8] = '{1'b0, 8'h01, 0, 4'd0, IDLE, 1'b1, 3'd0};

    rst_n    = 1'b0;
    led_in   = 8'h00;
    sync_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_duty", duty_out, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_phase", phase, IDLE);
    check("rst_err", onehot_err, 0);

    // Idle stream after reset release: meas_valid on the 6th and 12th sampled edge.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick(8'h00, 1'b0);
      check("idle_meas_valid", meas_valid, (k % 6 == 0) ? 1 : 0);
      check("idle_duty", duty_out, 0);
      check("idle_phase", phase, IDLE);
      check("idle_quiet", {led_change, breath_done, onehot_err, led_idx}, 0);
    end

    // Window-level table: steady duty, then a full 1,2,3,3,2,1,0 breath on LED 0.
    foreach (vecs[i]) run_window(vecs[i]);
`ifdef LED_MON_STATS_EN
    check("breath_cnt_one", breath_cnt, 1);
`endif

    // LED change: 04,04,08 pulses once; zeros afterwards do not.
    tick(8'h00, 1'b1);
    tick(8'h04, 1'b0);
    check("chg_first_suppressed", led_change, 0);
    check("chg_idx2", led_idx, 2);
    tick(8'h04, 1'b0);
    check("chg_same_idx", led_change, 0);
    tick(8'h08, 1'b0);
    check("chg_pulse", led_change, 1);
    check("chg_idx3", led_idx, 3);
    tick(8'h00, 1'b0);
    check("chg_zero_no_pulse", led_change, 0);
    check("chg_idx_hold", led_idx, 3);
    tick(8'h00, 1'b0);
    check("chg_zero_no_pulse2", led_change, 0);

    // Multi-hot sample: sticky error, index held, cycle counted in duty.
    tick(8'h00, 1'b1);
    tick(8'h0C, 1'b0);
    check("mh_err", onehot_err, 1);
    check("mh_idx_hold", led_idx, 3);
    check("mh_no_change", led_change, 0);
    for (int c = 1; c < 6; c++) tick(8'h00, 1'b0);
    check("mh_meas_valid", meas_valid, 1);
    check("mh_duty", duty_out, 1);
    check("mh_phase", phase, RISE);
    tick(8'h00, 1'b1);
    check("clr_err_kept", onehot_err, 1);
    check("clr_duty_kept", duty_out, 1);
    check("clr_idx_kept", led_idx, 3);
    check("clr_phase_idle", phase, IDLE);
    check("clr_meas_valid", meas_valid, 0);

    // sync_clr landing on the window-close cycle suppresses the measurement.
    for (int c = 0; c < 5; c++) tick(8'h01, 1'b0);
    check("coll_pre_meas_valid", meas_valid, 0);
    tick(8'h01, 1'b1);
    check("coll_meas_valid", meas_valid, 0);
    check("coll_done", breath_done, 0);
    check("coll_duty_kept", duty_out, 1);
    check("coll_phase", phase, IDLE);
    check("coll_err_kept", onehot_err, 1);

    // Reset in the middle of a window after a duty-5 measurement.
    tick(8'h00, 1'b1);
    for (int c = 0; c < 6; c++) tick((c < 5) ? 8'h01 : 8'h00, 1'b0);
    check("pre_rst_duty", duty_out, 5);
    for (int c = 0; c < 3; c++) tick(8'h01, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_duty", duty_out, 0);
    check("mid_rst_err", onehot_err, 0);
    check("mid_rst_phase", phase, IDLE);
    check("mid_rst_rest", {meas_valid, led_idx, led_change, breath_done}, 0);
`ifdef LED_MON_STATS_EN
    check("mid_rst_breath_cnt", breath_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick((k <= 4) ? 8'h02 : 8'h00, 1'b0);
      check("post_rst_meas_valid", meas_valid, (k == 6) ? 1 : 0);
      check("post_rst_change", led_change, 0);
    end
    check("post_rst_duty", duty_out, 4);
    check("post_rst_idx", led_idx, 1);
    check("post_rst_phase", phase, RISE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
